// File: rtl/tl45_fetch_if.sv
// Pipelined Wishbone-style instruction read bus between tl45_fetch (master) and memory (slave).
// The error line exists only when TL45_FETCH_BUSERR_EN is defined.
interface tl45_fetch_if;
    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;

    logic              o_wb_cyc;
    logic              o_wb_stb;
    logic [ADDR_W-1:0] o_wb_addr;
    logic              i_wb_stall;
    logic              i_wb_ack;
    logic [DATA_W-1:0] i_wb_data;
`ifdef TL45_FETCH_BUSERR_EN
    logic              i_wb_err;
`endif

    modport master (
        output o_wb_cyc,
        output o_wb_stb,
        output o_wb_addr,
        input  i_wb_stall,
        input  i_wb_ack,
`ifdef TL45_FETCH_BUSERR_EN
        input  i_wb_err,
`endif
        input  i_wb_data
    );

    modport slave (
        input  o_wb_cyc,
        input  o_wb_stb,
        input  o_wb_addr,
        output i_wb_stall,
        output i_wb_ack,
`ifdef TL45_FETCH_BUSERR_EN
        output i_wb_err,
`endif
        output i_wb_data
    );
endinterface

// File: rtl/tl45_fetch.sv
// tl45 instruction fetch stage: owns the PC, reads words over the pipelined bus into the fetch/decode buffer.
// Optional bus-error handling (FAULT state, i_wb_err, o_fault) is enabled by defining TL45_FETCH_BUSERR_EN.
module tl45_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'hF000_0000
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_pipe_stall,
    input  logic         i_pipe_flush,
    input  logic [31:0]  i_new_pc,
    tl45_fetch_if.master wb,
`ifdef TL45_FETCH_BUSERR_EN
    output logic         o_fault,
`endif
    output logic [31:0]  o_buf_pc,
    output logic [31:0]  o_buf_inst
);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned ADDR_W = 30;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_FULL  = 3'd3;
`ifdef TL45_FETCH_BUSERR_EN
    localparam logic [2:0] S_FAULT = 3'd4;
`endif

    logic [2:0]        state_q,    state_d;
    logic [XLEN-1:0]   pc_q,       pc_d;
    logic [XLEN-1:0]   pend_q,     pend_d;
    logic [XLEN-1:0]   buf_pc_q,   buf_pc_d;
    logic [XLEN-1:0]   buf_inst_q, buf_inst_d;
    logic              cyc_q,      cyc_d;
    logic              stb_q,      stb_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
`ifdef TL45_FETCH_BUSERR_EN
    logic              fault_q,    fault_d;
    logic              bus_err;
`endif

    logic accepted;
    logic word_done;

    // A strobe is taken when the slave is not stalling; an ack alongside it completes the read.
    assign accepted  = (state_q == S_REQ) && !wb.i_wb_stall;
    assign word_done = wb.i_wb_ack && (accepted || (state_q == S_WAIT));
`ifdef TL45_FETCH_BUSERR_EN
    assign bus_err   = wb.i_wb_err && (accepted || (state_q == S_WAIT));
`endif

    // Next-state and next-register computation.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = i_pipe_stall ? buf_inst_q : NOP_INST;
`ifdef TL45_FETCH_BUSERR_EN
        fault_d    = fault_q;
`endif

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (accepted) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: state_d = S_WAIT;
            S_FULL: begin
                if (!i_pipe_stall) begin
                    buf_pc_d   = pc_q;
                    buf_inst_d = pend_q;
                    pc_d       = pc_q + XLEN'(4);
                    state_d    = S_REQ;
                end
            end
`ifdef TL45_FETCH_BUSERR_EN
            S_FAULT: state_d = S_FAULT;
`endif
            default: state_d = S_IDLE;
        endcase

        if (word_done) begin
            if (!i_pipe_stall) begin
                buf_pc_d   = pc_q;
                buf_inst_d = wb.i_wb_data;
                pc_d       = pc_q + XLEN'(4);
                state_d    = S_REQ;
            end else begin
                pend_d  = wb.i_wb_data;
                state_d = S_FULL;
            end
        end

`ifdef TL45_FETCH_BUSERR_EN
        // An error beats a simultaneous ack; the PC stays on the faulting word.
        if (bus_err) begin
            pc_d       = pc_q;
            pend_d     = pend_q;
            buf_pc_d   = buf_pc_q;
            buf_inst_d = NOP_INST;
            fault_d    = 1'b1;
            state_d    = S_FAULT;
        end
`endif

        // Redirect wins over everything; dropping cyc next cycle aborts any read in flight.
        if (i_pipe_flush) begin
            pc_d       = i_new_pc & ~XLEN'(3);
            pend_d     = '0;
            buf_pc_d   = buf_pc_q;
            buf_inst_d = NOP_INST;
            state_d    = S_IDLE;
`ifdef TL45_FETCH_BUSERR_EN
            fault_d    = 1'b0;
`endif
        end

        cyc_d  = (state_d == S_REQ) || (state_d == S_WAIT);
        stb_d  = (state_d == S_REQ);
        addr_d = pc_d[XLEN-1:2];
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            pend_q     <= '0;
            buf_pc_q   <= '0;
            buf_inst_q <= NOP_INST;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            addr_q     <= '0;
`ifdef TL45_FETCH_BUSERR_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            addr_q     <= addr_d;
`ifdef TL45_FETCH_BUSERR_EN
            fault_q    <= fault_d;
`endif
        end
    end

    assign wb.o_wb_cyc  = cyc_q;
    assign wb.o_wb_stb  = stb_q;
    assign wb.o_wb_addr = addr_q;
    assign o_buf_pc     = buf_pc_q;
    assign o_buf_inst   = buf_inst_q;
`ifdef TL45_FETCH_BUSERR_EN
    assign o_fault      = fault_q;
`endif

endmodule

// File: tb/tb_tl45_fetch.sv
// Directed self-checking bench for tl45_fetch; the bus slave is driven cycle by cycle from each test task.
// The bus-error scenario is compiled in only when TL45_FETCH_BUSERR_EN is defined.
module tb_tl45_fetch;
    localparam logic [31:0] NOP = 32'hF000_0000;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_pipe_stall;
    logic        i_pipe_flush;
    logic [31:0] i_new_pc;
    logic [31:0] o_buf_pc;
    logic [31:0] o_buf_inst;
`ifdef TL45_FETCH_BUSERR_EN
    logic        o_fault;
`endif

    int n_cmp;
    int n_bad;

    tl45_fetch_if wb ();

    tl45_fetch #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (NOP)
    ) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_pipe_stall (i_pipe_stall),
        .i_pipe_flush (i_pipe_flush),
        .i_new_pc     (i_new_pc),
        .wb           (wb.master),
`ifdef TL45_FETCH_BUSERR_EN
        .o_fault      (o_fault),
`endif
        .o_buf_pc     (o_buf_pc),
        .o_buf_inst   (o_buf_inst)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Advance one clock; outputs are read 1 time unit after the rising edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset_n        = 1'b0;
        i_pipe_stall     = 1'b0;
        i_pipe_flush     = 1'b0;
        i_new_pc         = '0;
        wb.i_wb_stall    = 1'b0;
        wb.i_wb_ack      = 1'b0;
        wb.i_wb_data     = '0;
`ifdef TL45_FETCH_BUSERR_EN
        wb.i_wb_err      = 1'b0;
`endif
        step();
        step();
        n_cmp++; if (wb.o_wb_cyc !== 1'b0) begin n_bad++; $display("FAIL reset_cyc: got %b want 0", wb.o_wb_cyc); end
        n_cmp++; if (wb.o_wb_stb !== 1'b0) begin n_bad++; $display("FAIL reset_stb: got %b want 0", wb.o_wb_stb); end
        n_cmp++; if (wb.o_wb_addr !== 30'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", wb.o_wb_addr); end
        n_cmp++; if (o_buf_pc !== 32'h0) begin n_bad++; $display("FAIL reset_buf_pc: got %h want 0", o_buf_pc); end
        n_cmp++; if (o_buf_inst !== NOP) begin n_bad++; $display("FAIL reset_buf_inst: got %h want %h", o_buf_inst, NOP); end
`ifdef TL45_FETCH_BUSERR_EN
        n_cmp++; if (o_fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b want 0", o_fault); end
`endif
    endtask

    task automatic test_first_fetch();
        i_reset_n = 1'b1;
        n_cmp++; if (wb.o_wb_stb !== 1'b0) begin n_bad++; $display("FAIL idle_stb: got %b want 0", wb.o_wb_stb); end
        step();
        n_cmp++; if ({wb.o_wb_cyc, wb.o_wb_stb} !== 2'b11) begin n_bad++; $display("FAIL first_strobe: got %b want 11", {wb.o_wb_cyc, wb.o_wb_stb}); end
        n_cmp++; if (wb.o_wb_addr !== 30'h0) begin n_bad++; $display("FAIL first_addr: got %h want 0", wb.o_wb_addr); end
        step();
        n_cmp++; if ({wb.o_wb_cyc, wb.o_wb_stb} !== 2'b10) begin n_bad++; $display("FAIL wait_cyc_stb: got %b want 10", {wb.o_wb_cyc, wb.o_wb_stb}); end
        wb.i_wb_ack  = 1'b1;
        wb.i_wb_data = 32'h1000_0001;
        step();
        wb.i_wb_ack  = 1'b0;
        n_cmp++; if (o_buf_pc !== 32'h0) begin n_bad++; $display("FAIL first_buf_pc: got %h want 0", o_buf_pc); end
        n_cmp++; if (o_buf_inst !== 32'h1000_0001) begin n_bad++; $display("FAIL first_buf_inst: got %h want 10000001", o_buf_inst); end
        n_cmp++; if (wb.o_wb_stb !== 1'b1 || wb.o_wb_addr !== 30'h1) begin n_bad++; $display("FAIL second_strobe: got stb=%b addr=%h want stb=1 addr=1", wb.o_wb_stb, wb.o_wb_addr); end
    endtask

    task automatic test_pipe_stall();
        step();
        wb.i_wb_ack  = 1'b1;
        wb.i_wb_data = 32'h0000_4444;
        step();
        wb.i_wb_ack  = 1'b0;
        n_cmp++; if (o_buf_pc !== 32'h4 || o_buf_inst !== 32'h4444) begin n_bad++; $display("FAIL pc4_word: got pc=%h inst=%h want pc=4 inst=4444", o_buf_pc, o_buf_inst); end
        i_pipe_stall = 1'b1;
        step();
        wb.i_wb_ack  = 1'b1;
        wb.i_wb_data = 32'h0000_000A;
        step();
        wb.i_wb_ack  = 1'b0;
        n_cmp++; if (wb.o_wb_cyc !== 1'b0 || wb.o_wb_stb !== 1'b0) begin n_bad++; $display("FAIL full_bus_idle: got cyc=%b stb=%b want 0 0", wb.o_wb_cyc, wb.o_wb_stb); end
        n_cmp++; if (o_buf_pc !== 32'h4 || o_buf_inst !== 32'h4444) begin n_bad++; $display("FAIL full_hold: got pc=%h inst=%h want pc=4 inst=4444", o_buf_pc, o_buf_inst); end
        step();
        n_cmp++; if (wb.o_wb_cyc !== 1'b0 || o_buf_inst !== 32'h4444) begin n_bad++; $display("FAIL full_hold2: got cyc=%b inst=%h want 0 4444", wb.o_wb_cyc, o_buf_inst); end
        i_pipe_stall = 1'b0;
        step();
        n_cmp++; if (o_buf_pc !== 32'h8 || o_buf_inst !== 32'hA) begin n_bad++; $display("FAIL full_release: got pc=%h inst=%h want pc=8 inst=a", o_buf_pc, o_buf_inst); end
        n_cmp++; if (wb.o_wb_stb !== 1'b1 || wb.o_wb_addr !== 30'h3) begin n_bad++; $display("FAIL after_full_strobe: got stb=%b addr=%h want 1 3", wb.o_wb_stb, wb.o_wb_addr); end
    endtask

    task automatic test_wb_stall();
        wb.i_wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (wb.o_wb_stb !== 1'b1 || wb.o_wb_addr !== 30'h3) begin n_bad++; $display("FAIL wb_stall_hold%0d: got stb=%b addr=%h want 1 3", i, wb.o_wb_stb, wb.o_wb_addr); end
            n_cmp++; if (o_buf_inst !== NOP || o_buf_pc !== 32'h8) begin n_bad++; $display("FAIL wb_stall_nop%0d: got pc=%h inst=%h want 8 %h", i, o_buf_pc, o_buf_inst, NOP); end
        end
        wb.i_wb_stall = 1'b0;
    endtask

    task automatic test_back_to_back();
        wb.i_wb_ack  = 1'b1;
        wb.i_wb_data = 32'h0000_000C;
        step();
        n_cmp++; if (o_buf_pc !== 32'hC || o_buf_inst !== 32'hC || wb.o_wb_addr !== 30'h4) begin n_bad++; $display("FAIL b2b_first: got pc=%h inst=%h addr=%h want c c 4", o_buf_pc, o_buf_inst, wb.o_wb_addr); end
        wb.i_wb_data = 32'h0000_000D;
        step();
        wb.i_wb_ack  = 1'b0;
        n_cmp++; if (o_buf_pc !== 32'h10 || o_buf_inst !== 32'hD || wb.o_wb_addr !== 30'h5) begin n_bad++; $display("FAIL b2b_second: got pc=%h inst=%h addr=%h want 10 d 5", o_buf_pc, o_buf_inst, wb.o_wb_addr); end
    endtask

    task automatic test_flush();
        step();
        i_pipe_flush = 1'b1;
        i_new_pc     = 32'h0000_0103;
        wb.i_wb_ack  = 1'b1;
        wb.i_wb_data = 32'hDEAD_BEEF;
        step();
        i_pipe_flush = 1'b0;
        wb.i_wb_ack  = 1'b0;
        n_cmp++; if (wb.o_wb_cyc !== 1'b0 || wb.o_wb_stb !== 1'b0) begin n_bad++; $display("FAIL flush_abort: got cyc=%b stb=%b want 0 0", wb.o_wb_cyc, wb.o_wb_stb); end
        n_cmp++; if (o_buf_inst !== NOP || o_buf_pc !== 32'h10) begin n_bad++; $display("FAIL flush_buf: got pc=%h inst=%h want 10 %h", o_buf_pc, o_buf_inst, NOP); end
        step();
        n_cmp++; if (wb.o_wb_stb !== 1'b1 || wb.o_wb_addr !== 30'h40) begin n_bad++; $display("FAIL flush_new_strobe: got stb=%b addr=%h want 1 40", wb.o_wb_stb, wb.o_wb_addr); end
        step();
        n_cmp++; if (o_buf_inst !== NOP) begin n_bad++; $display("FAIL flush_nop_wait: got %h want %h", o_buf_inst, NOP); end
        wb.i_wb_ack  = 1'b1;
        wb.i_wb_data = 32'h0000_0055;
        step();
        wb.i_wb_ack  = 1'b0;
        n_cmp++; if (o_buf_pc !== 32'h100 || o_buf_inst !== 32'h55 || wb.o_wb_addr !== 30'h41) begin n_bad++; $display("FAIL flush_first_word: got pc=%h inst=%h addr=%h want 100 55 41", o_buf_pc, o_buf_inst, wb.o_wb_addr); end
    endtask

    task automatic test_wrap();
        i_pipe_flush = 1'b1;
        i_new_pc     = 32'hFFFF_FFFC;
        step();
        i_pipe_flush = 1'b0;
        step();
        n_cmp++; if (wb.o_wb_stb !== 1'b1 || wb.o_wb_addr !== 30'h3FFF_FFFF) begin n_bad++; $display("FAIL wrap_top_strobe: got stb=%b addr=%h want 1 3fffffff", wb.o_wb_stb, wb.o_wb_addr); end
        wb.i_wb_ack  = 1'b1;
        wb.i_wb_data = 32'h0000_0077;
        step();
        wb.i_wb_ack  = 1'b0;
        n_cmp++; if (o_buf_pc !== 32'hFFFF_FFFC || o_buf_inst !== 32'h77) begin n_bad++; $display("FAIL wrap_word: got pc=%h inst=%h want fffffffc 77", o_buf_pc, o_buf_inst); end
        n_cmp++; if (wb.o_wb_stb !== 1'b1 || wb.o_wb_addr !== 30'h0) begin n_bad++; $display("FAIL wrap_next_addr: got stb=%b addr=%h want 1 0", wb.o_wb_stb, wb.o_wb_addr); end
    endtask

`ifdef TL45_FETCH_BUSERR_EN
    task automatic test_bus_error();
        i_pipe_flush = 1'b1;
        i_new_pc     = 32'h0000_0020;
        step();
        i_pipe_flush = 1'b0;
        step();
        n_cmp++; if (wb.o_wb_addr !== 30'h8) begin n_bad++; $display("FAIL err_setup_addr: got %h want 8", wb.o_wb_addr); end
        wb.i_wb_err = 1'b1;
        step();
        wb.i_wb_err = 1'b0;
        n_cmp++; if (o_fault !== 1'b1 || wb.o_wb_cyc !== 1'b0) begin n_bad++; $display("FAIL err_fault: got fault=%b cyc=%b want 1 0", o_fault, wb.o_wb_cyc); end
        n_cmp++; if (o_buf_inst !== NOP) begin n_bad++; $display("FAIL err_nop: got %h want %h", o_buf_inst, NOP); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (wb.o_wb_stb !== 1'b0 || o_fault !== 1'b1) begin n_bad++; $display("FAIL err_parked%0d: got stb=%b fault=%b want 0 1", i, wb.o_wb_stb, o_fault); end
        end
        i_pipe_flush = 1'b1;
        i_new_pc     = 32'h0;
        step();
        i_pipe_flush = 1'b0;
        n_cmp++; if (o_fault !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b want 0", o_fault); end
        step();
        n_cmp++; if (wb.o_wb_stb !== 1'b1 || wb.o_wb_addr !== 30'h0) begin n_bad++; $display("FAIL err_resume: got stb=%b addr=%h want 1 0", wb.o_wb_stb, wb.o_wb_addr); end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_first_fetch();
        test_pipe_stall();
        test_wb_stall();
        test_back_to_back();
        test_flush();
        test_wrap();
`ifdef TL45_FETCH_BUSERR_EN
        test_bus_error();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
